// File: rtl/analyzer_spi_pkg.sv
// Shared definitions for the analyzer SPI master: command codes, header size, FSM states.
// frame_len() gives the number of SCLK bits a command occupies on the wire.
package analyzer_spi_pkg;

   localparam logic [1:0] CODE_DATA    = 2'd0;
   localparam logic [1:0] CODE_START   = 2'd1;
   localparam logic [1:0] CODE_MASK    = 2'd2;
   localparam logic [1:0] CODE_PATTERN = 2'd3;

   localparam int HDR_BITS = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LOW,
      ST_HIGH,
      ST_TAIL
   } spi_state_t;

   // Start frames carry a single flag bit; every other code carries a full data word.
   function automatic int frame_len(input logic [1:0] code, input int data_w);
      return (code == CODE_START) ? (HDR_BITS + 1) : (HDR_BITS + data_w);
   endfunction

endpackage

// File: rtl/analyzer_spi_master_if.sv
// Command handshake, match result and SPI pins of the analyzer SPI master.
// master = the SPI master block itself; slave = the host/sequencer plus the SPI target.
interface analyzer_spi_master_if #(
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_code;
   logic [DATA_W-1:0] cmd_data;
   logic              match_valid;
   logic              match;
   logic              busy;
   logic              SCLK;
   logic              MOSI;
   logic              MISO;
   logic              SS;

   modport master (
      input  cmd_valid, cmd_code, cmd_data, MISO,
      output cmd_ready, match_valid, match, busy, SCLK, MOSI, SS
   );

   modport slave (
      output cmd_valid, cmd_code, cmd_data, MISO,
      input  cmd_ready, match_valid, match, busy, SCLK, MOSI, SS
   );
endinterface

// File: rtl/analyzer_spi_clkgen.sv
// SCLK half-period timer: counts CLK_DIV cycles per phase, toggles SCLK when enabled, flags rise/fall.
// Strobes are combinational and mark the cycle whose closing edge changes SCLK; idle forces SCLK low.
module analyzer_spi_clkgen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic count,
   input  logic toggle_en,
   output logic sclk,
   output logic half_done,
   output logic half_last,
   output logic rise,
   output logic fall
);
   localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

   logic [7:0] cnt;

   // The counter reloads whenever it is not counting, so every phase starts from a full half-period.
   always_ff @(posedge clk) begin
      if (rst || !count) begin
         cnt  <= RELOAD;
         sclk <= 1'b0;
      end else if (cnt == 8'd0) begin
         cnt <= RELOAD;
         if (toggle_en) begin
            sclk <= ~sclk;
         end
      end else begin
         cnt <= cnt - 8'd1;
      end
   end

   assign half_done = count && (cnt == 8'd0);
   assign half_last = count && (cnt == 8'd1);
   assign rise      = half_done && toggle_en && !sclk;
   assign fall      = half_done && toggle_en && sclk;

endmodule

// File: rtl/analyzer_spi_master.sv
// SPI master: one command per frame (3-bit header + payload, MSB first, mode 0), match flag returned for data frames.
// Occupancy 1 + 2*L*CLK_DIV + CLK_DIV cycles; cmd_ready only in IDLE. ANALYZER_SPI_MATCH_CNT_EN adds match_count.
module analyzer_spi_master
   import analyzer_spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 32
) (
   input  logic CLK,
   input  logic RST,
   analyzer_spi_master_if.master bus
`ifdef ANALYZER_SPI_MATCH_CNT_EN
   ,
   output logic [15:0] match_count
`endif
);
   localparam int FRAME_W = HDR_BITS + DATA_W;

   spi_state_t         state;
   spi_state_t         state_n;
   logic [1:0]         code_q;
   logic [FRAME_W-1:0] sh;
   logic [5:0]         bit_cnt;
   logic               ss_q;
   logic               match_q;
   logic               match_valid_q;

   logic accept;
   logic shift;
   logic finish;
   logic sample;
   logic count;
   logic toggle_en;
   logic sclk;
   logic half_done;
   logic half_last;
   logic rise;
   logic fall;

   assign count     = (state == ST_LOW) || (state == ST_HIGH) || (state == ST_TAIL);
   assign toggle_en = (state == ST_LOW) || (state == ST_HIGH);

   analyzer_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk       (CLK),
      .rst       (RST),
      .count     (count),
      .toggle_en (toggle_en),
      .sclk      (sclk),
      .half_done (half_done),
      .half_last (half_last),
      .rise      (rise),
      .fall      (fall)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      shift   = 1'b0;
      finish  = 1'b0;
      sample  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               accept  = 1'b1;
               state_n = ST_LOAD;
            end
         end
         ST_LOAD: state_n = ST_LOW;
         ST_LOW: begin
            if (rise) begin
               state_n = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (fall) begin
               if (bit_cnt == 6'd0) begin
                  state_n = ST_TAIL;
               end else begin
                  shift   = 1'b1;
                  state_n = ST_LOW;
               end
            end
         end
         ST_TAIL: begin
            // Registered result lands exactly in the final TAIL cycle.
            sample = half_last && (code_q == CODE_DATA);
            if (half_done) begin
               finish  = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         code_q        <= CODE_DATA;
         sh            <= '0;
         bit_cnt       <= '0;
         ss_q          <= 1'b0;
         match_q       <= 1'b0;
         match_valid_q <= 1'b0;
      end else begin
         match_valid_q <= sample;
         ss_q          <= (state_n != ST_IDLE);
         if (accept) begin
            code_q  <= bus.cmd_code;
            bit_cnt <= 6'(frame_len(bus.cmd_code, DATA_W) - 1);
            // Frame is left-aligned so MOSI is always the shifter MSB.
            if (bus.cmd_code == CODE_START) begin
               sh <= {1'b0, bus.cmd_code, bus.cmd_data[0], {(FRAME_W-4){1'b0}}};
            end else begin
               sh <= {1'b0, bus.cmd_code, bus.cmd_data};
            end
         end else if (shift) begin
            sh      <= {sh[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - 6'd1;
         end else if (finish) begin
            sh <= '0;
         end
         if (sample) begin
            match_q <= bus.MISO;
         end
      end
   end

`ifdef ANALYZER_SPI_MATCH_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         match_count <= '0;
      end else if (sample && bus.MISO && (match_count != 16'hFFFF)) begin
         match_count <= match_count + 16'd1;
      end
   end
`endif

   assign bus.cmd_ready   = (state == ST_IDLE);
   assign bus.busy        = (state != ST_IDLE);
   assign bus.SS          = ss_q;
   assign bus.SCLK        = sclk;
   assign bus.MOSI        = sh[FRAME_W-1];
   assign bus.match       = match_q;
   assign bus.match_valid = match_valid_q;

endmodule
